controlador_memoria: RTL
========================

Name: controlador_memoria

Overview:
- Initiator for the nRISC data memory (`memoria_dados`): accepts commands from the core or a test harness and drives the memory strobes.
- Memory-side signals are `Endereco`, `DadoEscr`, `EscMem` and `LerMem`; read data returns on `DadoLido`.
- Supported operations: single read, single write, block copy, block fill.
- Sequences the memory's one-cycle registered-read timing and returns a one-cycle response pulse with data and error status.

Parameters:
- `ADDR_W`, 8: width of the address bus and of `cmd_len`.
- `DATA_W`, 8: data width.
- `MEM_DEPTH`, 128: number of valid memory locations; addresses >= `MEM_DEPTH` are illegal.

Ports:
- `clock`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_op`  in  2  00 read, 01 write, 10 copy, 11 fill.
- `cmd_src`  in  ADDR_W  source address (read, copy).
- `cmd_dst`  in  ADDR_W  destination address (write, copy, fill).
- `cmd_len`  in  ADDR_W  byte count (copy, fill).
- `cmd_data`  in  DATA_W  write/fill data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  DATA_W  read data, written data, or last byte moved.
- `rsp_err`  out  1  qualified by `rsp_valid`; command rejected or failed.
- `busy`  out  1  state != IDLE.
- `Endereco`  out  ADDR_W  memory address.
- `DadoEscr`  out  DATA_W  memory write data.
- `EscMem`  out  1  memory write strobe.
- `LerMem`  out  1  memory read strobe.
- `DadoLido`  in  DATA_W  memory read data, valid the cycle after a `LerMem` edge.

Behaviour:
- Reset (`reset`==0 at posedge) returns the FSM to IDLE. All outputs go to 0 except `cmd_ready`, which goes to 1. Reset aborts any block operation mid-transfer; bytes already written stay written.
- States: IDLE, RD, RD_WAIT, WR, ERR, DONE.
- Memory-side outputs are registered or decoded from registered state only; there is no combinational path from `cmd_*` to the memory pins.
- `EscMem` and `LerMem` are never high together.
- In IDLE, ERR and DONE, `Endereco`, `DadoEscr`, `EscMem` and `LerMem` are all 0.
- Handshake: a command is accepted at a posedge with `cmd_valid` && `cmd_ready`. All `cmd_*` fields are latched at acceptance. `cmd_*` is ignored while `cmd_ready`=0.
- Range check at acceptance uses ADDR_W+1-bit arithmetic:
  - read: `src` < `MEM_DEPTH`.
  - write: `dst` < `MEM_DEPTH`.
  - copy: `src`+`len` <= `MEM_DEPTH` and `dst`+`len` <= `MEM_DEPTH`.
  - fill: `dst`+`len` <= `MEM_DEPTH`.
  - On failure go to ERR: no memory access, `rsp_valid`=1 and `rsp_err`=1 in the next cycle, `rsp_data`=0. There is no address wrap-around.
- Single read: RD (`LerMem`=1, `Endereco`=`src`), then RD_WAIT, capturing `DadoLido` at the end of RD_WAIT, then DONE. `rsp_valid` is high in the 3rd cycle after the accept edge.
- Single write: WR (`EscMem`=1, `Endereco`=`dst`, `DadoEscr`=`data`), then DONE. `rsp_valid` is high in the 2nd cycle after acceptance; `rsp_data`=`data`.
- Copy: per byte i, in ascending order: RD at `src`+i, RD_WAIT capturing into a holding register, then WR at `dst`+i with the held byte. That is 3 cycles per byte, then DONE. `rsp_data` = last byte copied. Overlapping regions are copied in ascending order with no overlap correction.
- Fill: WR at `dst`+i with `data` for i = 0..`len`-1, one byte per cycle, then DONE.
- `len`=0 for copy or fill: go straight to DONE. No memory access, `rsp_err`=0, `rsp_data`=0.
- DONE: `rsp_valid`=1 for exactly one cycle, then IDLE. `cmd_ready` returns to 1 in the cycle after DONE. `rsp_data` and `rsp_err` hold until the next response.
- Byte counter and address offsets are ADDR_W+1 bits internally.

Optional Feature:
- Macro: `CONTROLADOR_MEMORIA_VERIFY_EN`.
- When defined:
  - Every WR (single, copy, fill) is followed by a verify read: VRD with `LerMem`=1 at the same address, then VRD_WAIT comparing `DadoLido` to the written byte. This adds 2 cycles per written byte.
  - On a mismatch, stop the operation at that byte, go to DONE with `rsp_err`=1, and set `rsp_data` = the byte read back.
- When undefined: no verify states; timing is as described in Behaviour.

Test Plan:
- Reset: hold `reset`=0 for 2 cycles -> `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `EscMem`=`LerMem`=0, `Endereco`=0.
- Write then read: write `dst`=50 `data`=100 -> `EscMem` pulse with `Endereco`=50 and `DadoEscr`=100, `rsp_valid` 2 cycles after accept. Then read `src`=50 -> `rsp_data`=100 3 cycles after accept, `rsp_err`=0.
- Fill then copy: fill `dst`=10 `len`=4 `data`=0xA5, then copy `src`=10 `dst`=20 `len`=4.
  - Reads of 20..23 all return 0xA5.
  - The copy takes 12 memory cycles; `rsp_data`=0xA5.
- Range errors: read `src`=128 -> `rsp_err`=1 one cycle after accept, no strobes. Fill `dst`=125 `len`=4 -> `rsp_err`=1, location 125 unchanged. Fill `dst`=124 `len`=4 -> ok.
- Reset mid-copy: copy `len`=8, assert `reset`=0 after the 2nd WR -> next cycle IDLE with outputs 0. Destination bytes 0..1 written, 2..7 unchanged.
- Handshake and `len`=0: `cmd_valid` held high while busy -> only one command accepted. Copy `len`=0 -> `rsp_valid` next cycle, no strobes. Memory pre-seeded with a stuck byte under the verify macro -> `rsp_err`=1 on fill.

Source files
------------

// File: rtl/controlador_memoria.sv
// Memory initiator for the nRISC data memory: read, write, block copy and block fill.
// Optional read-back verify of every written byte: define CONTROLADOR_MEMORIA_VERIFY_EN.
module controlador_memoria #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] Endereco,
   output logic [DATA_W-1:0] DadoEscr,
   output logic              EscMem,
   output logic              LerMem,
   input  logic [DATA_W-1:0] DadoLido
);

   localparam int AW1 = ADDR_W + 1;
   localparam logic [AW1-1:0] DEPTH = AW1'(MEM_DEPTH);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_FILL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RD_WAIT,
      S_WR,
      S_ERR,
      S_DONE
`ifdef CONTROLADOR_MEMORIA_VERIFY_EN
      ,
      S_VRD,
      S_VRD_WAIT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [AW1-1:0]    len_q, len_d;
   logic [AW1-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic [AW1-1:0]    c_src, c_dst, c_len;
   logic              cmd_ok;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [DATA_W-1:0] wbyte;
   logic              last_byte;
   logic              advance;

   assign c_src = {1'b0, cmd_src};
   assign c_dst = {1'b0, cmd_dst};
   assign c_len = {1'b0, cmd_len};

   always_comb begin
      cmd_ok = 1'b0;
      case (cmd_op)
         OP_READ:  cmd_ok = (c_src < DEPTH);
         OP_WRITE: cmd_ok = (c_dst < DEPTH);
         OP_COPY:  cmd_ok = ((c_src + c_len) <= DEPTH) && ((c_dst + c_len) <= DEPTH);
         default:  cmd_ok = ((c_dst + c_len) <= DEPTH);
      endcase
   end

   // Range check at acceptance guarantees these offsets never exceed ADDR_W bits.
   assign rd_addr   = src_q + cnt_q[ADDR_W-1:0];
   assign wr_addr   = dst_q + cnt_q[ADDR_W-1:0];
   assign wbyte     = (op_q == OP_COPY) ? hold_q : data_q;
   assign last_byte = (op_q == OP_WRITE) || ((cnt_q + AW1'(1)) == len_q);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      hold_d     = hold_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      advance    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               src_d  = cmd_src;
               dst_d  = cmd_dst;
               len_d  = c_len;
               data_d = cmd_data;
               cnt_d  = '0;
               if (!cmd_ok) begin
                  state_d    = S_ERR;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else if (cmd_op == OP_READ) begin
                  state_d = S_RD;
               end else if (cmd_op == OP_WRITE) begin
                  state_d = S_WR;
               end else if (c_len == '0) begin
                  state_d    = S_DONE;
                  rsp_err_d  = 1'b0;
                  rsp_data_d = '0;
               end else begin
                  state_d = (cmd_op == OP_COPY) ? S_RD : S_WR;
               end
            end
         end
         S_RD:      state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (op_q == OP_READ) begin
               state_d    = S_DONE;
               rsp_data_d = DadoLido;
               rsp_err_d  = 1'b0;
            end else begin
               hold_d  = DadoLido;
               state_d = S_WR;
            end
         end
`ifdef CONTROLADOR_MEMORIA_VERIFY_EN
         S_WR:       state_d = S_VRD;
         S_VRD:      state_d = S_VRD_WAIT;
         S_VRD_WAIT: begin
            if (DadoLido != wbyte) begin
               state_d    = S_DONE;
               rsp_data_d = DadoLido;
               rsp_err_d  = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
`else
         S_WR:      advance = 1'b1;
`endif
         S_ERR:     state_d = S_IDLE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // A byte has been written (and verified, if enabled): finish or move to the next one.
      if (advance) begin
         if (last_byte) begin
            state_d    = S_DONE;
            rsp_data_d = wbyte;
            rsp_err_d  = 1'b0;
         end else begin
            cnt_d   = cnt_q + AW1'(1);
            state_d = (op_q == OP_COPY) ? S_RD : S_WR;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         hold_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         hold_q     <= hold_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_DONE) || (state_q == S_ERR);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      Endereco = '0;
      DadoEscr = '0;
      EscMem   = 1'b0;
      LerMem   = 1'b0;
      case (state_q)
         S_RD: begin
            LerMem   = 1'b1;
            Endereco = rd_addr;
         end
         S_WR: begin
            EscMem   = 1'b1;
            Endereco = wr_addr;
            DadoEscr = wbyte;
         end
`ifdef CONTROLADOR_MEMORIA_VERIFY_EN
         S_VRD: begin
            LerMem   = 1'b1;
            Endereco = wr_addr;
         end
`endif
         default: ;
      endcase
   end

endmodule
